// File: rtl/sha3_axis_absorber.sv
// AXI-Stream byte packer for Keccak-f[1600]: fills rate-sized blocks, applies SHA3/SHAKE padding on TLAST.
// Optional SHAKE support via `define SHA3_ABSORB_SHAKE_EN; default build handles SHA3-224/256/384/512 only.
module sha3_axis_absorber #(
  parameter int WIDTH = 16
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [WIDTH-1:0]   S_TDATA,
  input  logic [WIDTH/8-1:0] S_TKEEP,
  input  logic               S_TLAST,
  input  logic [2:0]         S_TUSER,
  input  logic               S_TVALID,
  output logic               S_TREADY,
  output logic [1599:0]      BLK_DATA,
  output logic [4:0]         BLK_RATE_LANES,
  output logic [2:0]         BLK_MODE,
  output logic               BLK_FIRST,
  output logic               BLK_LAST,
  output logic               BLK_VALID,
  input  logic               BLK_READY,
  output logic               ERR
);
  localparam int NB = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, FILL, HOLD, PADBLK} state_t;

  state_t              r_state;
  state_t              r_ret;
  logic                r_live;
  logic [199:0][7:0]   r_blk;
  logic [7:0]          r_cnt;
  logic [2:0]          r_mode;
  logic [4:0]          r_lanes;
  logic                r_vld;
  logic                r_first;
  logic                r_last;
  logic                r_err;
  logic                r_sent;

  logic [NB-1:0][7:0]  w_dat;
  logic                w_acc;
  logic [2:0]          w_mode;
  logic                w_mode_err;
  logic [7:0]          w_rate;
  logic [7:0]          w_pad;
  logic                w_gap;
  logic                w_keep_err;
  logic [NB-1:0]       w_keep;
  logic [7:0]          w_n;
  logic [7:0]          w_end;
  logic [199:0][7:0]   w_blk;

  function automatic logic [7:0] rate_of(input logic [2:0] m);
`ifdef SHA3_ABSORB_SHAKE_EN
    if (m[2]) return m[0] ? 8'd136 : 8'd168;
`endif
    case (m[1:0])
      2'd0:    return 8'd144;
      2'd1:    return 8'd136;
      2'd2:    return 8'd104;
      default: return 8'd72;
    endcase
  endfunction

  assign w_dat    = S_TDATA;
  assign S_TREADY = r_live && (r_state == IDLE || r_state == FILL) && !r_vld;
  assign w_acc    = S_TVALID && S_TREADY;

  // Mode is taken live from S_TUSER only on the first beat of a message.
  always_comb begin
    w_mode     = r_mode;
    w_mode_err = 1'b0;
    if (r_state == IDLE) begin
`ifdef SHA3_ABSORB_SHAKE_EN
      w_mode = S_TUSER;
`else
      w_mode     = {1'b0, S_TUSER[1:0]};
      w_mode_err = S_TUSER[2];
`endif
    end
  end

  assign w_rate = rate_of(w_mode);
  assign w_pad  = w_mode[2] ? 8'h1F : 8'h06;

  always_comb begin
    w_gap = 1'b0;
    for (int i = 1; i < NB; i++) begin
      if (!S_TKEEP[i] && S_TKEEP[i-1]) w_gap = 1'b1;
    end
  end

  assign w_keep_err = (!S_TLAST && (S_TKEEP != {NB{1'b1}})) || (S_TLAST && w_gap);
  assign w_keep     = w_keep_err ? {NB{1'b1}} : S_TKEEP;

  // Rates are multiples of 8 bytes, so a beat never straddles the rate boundary.
  always_comb begin
    w_n = '0;
    for (int i = 0; i < NB; i++) w_n = w_n + 8'(w_keep[i]);
  end

  assign w_end = r_cnt + w_n;

  always_comb begin
    w_blk = r_blk;
    for (int j = 0; j < NB; j++) begin
      if (w_keep[NB-1-j]) w_blk[r_cnt + 8'(j)] = w_dat[NB-1-j];
    end
    if (S_TLAST && (w_end < w_rate)) begin
      w_blk[w_end]         = w_blk[w_end] ^ w_pad;
      w_blk[w_rate - 8'd1] = w_blk[w_rate - 8'd1] ^ 8'h80;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= IDLE;
      r_ret   <= IDLE;
      r_live  <= 1'b0;
      r_blk   <= '0;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_lanes <= '0;
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_sent  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        IDLE, FILL: begin
          if (w_acc) begin
            r_blk <= w_blk;
            r_err <= r_err | w_keep_err | w_mode_err;
            if (r_state == IDLE) begin
              r_mode  <= w_mode;
              r_lanes <= 5'(w_rate >> 3);
            end
            if (S_TLAST || (w_end == w_rate)) begin
              r_vld   <= 1'b1;
              r_first <= !r_sent;
              r_last  <= S_TLAST && (w_end < w_rate);
              r_cnt   <= '0;
              r_state <= HOLD;
              if (!S_TLAST)            r_ret <= FILL;
              else if (w_end < w_rate) r_ret <= IDLE;
              else                     r_ret <= PADBLK;
            end else begin
              r_cnt   <= w_end;
              r_state <= FILL;
            end
          end
        end
        HOLD: begin
          if (BLK_READY) begin
            r_vld   <= 1'b0;
            r_blk   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_sent  <= (r_ret != IDLE);
            r_state <= r_ret;
          end
        end
        PADBLK: begin
          // Message ended exactly on the rate: emit a block holding only padding.
          r_blk[0]             <= w_pad;
          r_blk[w_rate - 8'd1] <= 8'h80;
          r_vld   <= 1'b1;
          r_first <= 1'b0;
          r_last  <= 1'b1;
          r_ret   <= IDLE;
          r_state <= HOLD;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BLK_DATA       = r_blk;
  assign BLK_RATE_LANES = r_lanes;
  assign BLK_MODE       = r_mode;
  assign BLK_FIRST      = r_first;
  assign BLK_LAST       = r_last;
  assign BLK_VALID      = r_vld;
  assign ERR            = r_err;

endmodule

// File: tb/tb_sha3_axis_absorber.sv
// Bench for sha3_axis_absorber: random messages checked against a byte-level padding model.
module tb_sha3_axis_absorber;
  localparam int WIDTH = 16;
  localparam int NB    = WIDTH / 8;

  logic               ACLK = 1'b0;
  logic               ARESET = 1'b1;
  logic [WIDTH-1:0]   S_TDATA = '0;
  logic [NB-1:0]      S_TKEEP = '0;
  logic               S_TLAST = 1'b0;
  logic [2:0]         S_TUSER = '0;
  logic               S_TVALID = 1'b0;
  logic               S_TREADY;
  logic [1599:0]      BLK_DATA;
  logic [4:0]         BLK_RATE_LANES;
  logic [2:0]         BLK_MODE;
  logic               BLK_FIRST;
  logic               BLK_LAST;
  logic               BLK_VALID;
  logic               BLK_READY = 1'b0;
  logic               ERR;

  always #5 ACLK = ~ACLK;

  sha3_axis_absorber #(.WIDTH(WIDTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST), .S_TUSER(S_TUSER),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
    .BLK_DATA(BLK_DATA), .BLK_RATE_LANES(BLK_RATE_LANES), .BLK_MODE(BLK_MODE),
    .BLK_FIRST(BLK_FIRST), .BLK_LAST(BLK_LAST), .BLK_VALID(BLK_VALID),
    .BLK_READY(BLK_READY), .ERR(ERR)
  );

  int total = 0;
  int bad   = 0;

  byte unsigned      g_msg[$];
  logic [WIDTH-1:0]  bq_dat[$];
  logic [NB-1:0]     bq_keep[$];
  bit                bq_last[$];
  logic [2:0]        bq_user[$];
  logic [1599:0]     eq_blk[$];
  bit                eq_first[$];
  bit                eq_last[$];
  logic [2:0]        exp_mode;
  logic [4:0]        exp_lanes;
  logic [1599:0]     last_blk;
  bit                last_first;
  bit                last_last;

  task automatic chk(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rate_bytes(input logic [2:0] m);
`ifdef SHA3_ABSORB_SHAKE_EN
    if (m[2]) return m[0] ? 136 : 168;
`endif
    case (m[1:0])
      2'd0:    return 144;
      2'd1:    return 136;
      2'd2:    return 104;
      default: return 72;
    endcase
  endfunction

  // Standard SHA3 byte padding over the whole message, then cut into rate-sized blocks.
  task automatic model(input logic [2:0] tuser);
    byte unsigned pb[];
    logic [2:0]    m;
    logic [1599:0] blk;
    int rate, len, plen, nblk;
    m = tuser;
`ifndef SHA3_ABSORB_SHAKE_EN
    m[2] = 1'b0;
`endif
    rate = rate_bytes(m);
    len  = g_msg.size();
    plen = (len / rate + 1) * rate;
    nblk = plen / rate;
    pb = new[plen];
    foreach (pb[i]) pb[i] = 8'h00;
    for (int i = 0; i < len; i++) pb[i] = g_msg[i];
    pb[len]    = pb[len] ^ (m[2] ? 8'h1F : 8'h06);
    pb[plen-1] = pb[plen-1] ^ 8'h80;
    eq_blk.delete(); eq_first.delete(); eq_last.delete();
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int k = 0; k < rate; k++) blk[8*k +: 8] = pb[b*rate + k];
      eq_blk.push_back(blk);
      eq_first.push_back(b == 0);
      eq_last.push_back(b == nblk - 1);
    end
    exp_mode  = m;
    exp_lanes = 5'(rate / 8);
  endtask

  task automatic make_beats(input logic [2:0] tuser, input bit empty_tail);
    int i, rem;
    logic [WIDTH-1:0] d;
    logic [NB-1:0]    k;
    i = 0;
    bq_dat.delete(); bq_keep.delete(); bq_last.delete(); bq_user.delete();
    while (1) begin
      rem = g_msg.size() - i;
      d = WIDTH'($urandom);
      k = '0;
      for (int j = 0; j < NB; j++) begin
        if (j < rem) begin
          d[WIDTH-1-8*j -: 8] = g_msg[i+j];
          k[NB-1-j] = 1'b1;
        end
      end
      bq_dat.push_back(d);
      bq_keep.push_back(k);
      bq_user.push_back(bq_user.size() == 0 ? tuser : 3'($urandom));
      if (rem > NB || (rem == NB && empty_tail)) begin
        bq_last.push_back(1'b0);
        i += NB;
      end else begin
        bq_last.push_back(1'b1);
        break;
      end
    end
  endtask

  task automatic drive(input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      bit rdy;
      int cyc;
      repeat ($urandom_range(0, 2)) @(negedge ACLK);
      S_TDATA  = bq_dat[b];
      S_TKEEP  = bq_keep[b];
      S_TLAST  = bq_last[b];
      S_TUSER  = bq_user[b];
      S_TVALID = 1'b1;
      cyc = 0;
      do begin
        rdy = S_TREADY;
        @(negedge ACLK);
        cyc++;
      end while (!rdy && cyc < 2000);
      S_TVALID = 1'b0;
      chk("beat_accept", rdy, 1);
      if (!rdy) break;
    end
  endtask

  task automatic collect();
    int got, cyc;
    bit held;
    logic [1599:0] held_dat;
    got = 0; cyc = 0; held = 0; held_dat = '0;
    while (got < eq_blk.size() && cyc < 8000) begin
      @(negedge ACLK);
      cyc++;
      BLK_READY = ($urandom_range(0, 3) != 0);
      if (BLK_VALID) begin
        if (held) chk("blk_stable", BLK_DATA, held_dat);
        if (BLK_READY) begin
          chk("blk_data",  BLK_DATA,       eq_blk[got]);
          chk("blk_first", BLK_FIRST,      eq_first[got]);
          chk("blk_last",  BLK_LAST,       eq_last[got]);
          chk("blk_mode",  BLK_MODE,       exp_mode);
          chk("blk_lanes", BLK_RATE_LANES, exp_lanes);
          last_blk   = BLK_DATA;
          last_first = BLK_FIRST;
          last_last  = BLK_LAST;
          got++;
          held = 0;
        end else begin
          held = 1;
          held_dat = BLK_DATA;
        end
      end
    end
    @(negedge ACLK);
    BLK_READY = 1'b0;
    if (got < eq_blk.size()) chk("blk_count", got, eq_blk.size());
  endtask

  task automatic xfer();
    fork
      drive(bq_dat.size());
      collect();
    join
    repeat (3) @(negedge ACLK);
    chk("idle_no_block", BLK_VALID, 0);
  endtask

  task automatic run_msg(input logic [2:0] tuser, input bit empty_tail);
    model(tuser);
    make_beats(tuser, empty_tail);
    xfer();
  endtask

  task automatic set_abc();
    g_msg.delete();
    g_msg.push_back(8'h61); g_msg.push_back(8'h62); g_msg.push_back(8'h63);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1; S_TVALID = 1'b0; BLK_READY = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
  endtask

  initial begin
    logic [1599:0] snap;
    int cyc;
    logic [2:0] tu;

    repeat (2) @(negedge ACLK);
    chk("rst_tready", S_TREADY, 0);
    chk("rst_valid",  BLK_VALID, 0);
    chk("rst_first",  BLK_FIRST, 0);
    chk("rst_last",   BLK_LAST, 0);
    chk("rst_data",   BLK_DATA, 0);
    chk("rst_mode",   BLK_MODE, 0);
    chk("rst_lanes",  BLK_RATE_LANES, 0);
    chk("rst_err",    ERR, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_tready_rise", S_TREADY, 1);

    // Empty message, mode 1
    g_msg.delete();
    run_msg(3'd1, 1'b0);
    chk("empty_b0",    last_blk[7:0], 8'h06);
    chk("empty_b135",  last_blk[135*8 +: 8], 8'h80);
    chk("empty_flags", {last_first, last_last}, 2'b11);

    // "abc", mode 1
    set_abc();
    run_msg(3'd1, 1'b0);
    chk("abc_bytes", last_blk[31:0], 32'h06636261);
    chk("abc_b135",  last_blk[135*8 +: 8], 8'h80);

    // Exact-rate 136-byte message, mode 1
    g_msg.delete();
    for (int i = 0; i < 136; i++) g_msg.push_back(8'($urandom));
    run_msg(3'd1, 1'b0);
    chk("r136_padblk_first", last_first, 0);
    chk("r136_padblk_b0",    last_blk[7:0], 8'h06);

    // 71-byte message, mode 3: pad and end marker share byte 71
    g_msg.delete();
    for (int i = 0; i < 71; i++) g_msg.push_back(8'($urandom));
    run_msg(3'd3, 1'b0);
    chk("m71_b71", last_blk[71*8 +: 8], 8'h86);

    // Backpressure: hold BLK_READY low 10 cycles in HOLD
    set_abc();
    model(3'd1);
    make_beats(3'd1, 1'b0);
    BLK_READY = 1'b0;
    drive(bq_dat.size());
    cyc = 0;
    while (!BLK_VALID && cyc < 100) begin @(negedge ACLK); cyc++; end
    chk("bp_valid", BLK_VALID, 1);
    snap = BLK_DATA;
    chk("bp_data", snap, eq_blk[0]);
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      chk("bp_tready_low", S_TREADY, 0);
      chk("bp_hold_data", BLK_DATA, snap);
    end
    BLK_READY = 1'b1;
    @(negedge ACLK);
    BLK_READY = 1'b0;
    chk("bp_valid_drop", BLK_VALID, 0);
    chk("bp_tready_back", S_TREADY, 1);

    // Random messages
    for (int t = 0; t < 20; t++) begin
      g_msg.delete();
      for (int i = 0; i < $urandom_range(0, 320); i++) g_msg.push_back(8'($urandom));
      tu = 3'($urandom_range(0, 3));
`ifdef SHA3_ABSORB_SHAKE_EN
      tu[2] = 1'($urandom_range(0, 1));
`endif
      run_msg(tu, 1'($urandom_range(0, 1)));
      chk("rand_err", ERR, 0);
    end

    // Reset in the middle of a fill, then a clean "abc"
    g_msg.delete();
    for (int i = 0; i < 40; i++) g_msg.push_back(8'($urandom));
    make_beats(3'd1, 1'b0);
    drive(3);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("midrst_data",   BLK_DATA, 0);
    chk("midrst_tready", S_TREADY, 0);
    chk("midrst_valid",  BLK_VALID, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    set_abc();
    run_msg(3'd1, 1'b0);
    chk("midrst_abc_err", ERR, 0);

    // Partial TKEEP on a non-last beat: error, beat taken as full
    g_msg.delete();
    for (int i = 0; i < 4; i++) g_msg.push_back(8'($urandom));
    model(3'd1);
    make_beats(3'd1, 1'b0);
    bq_keep[0] = 2'b01;
    xfer();
    chk("keep_err", ERR, 1);
    set_abc();
    run_msg(3'd2, 1'b0);
    chk("keep_err_sticky", ERR, 1);

    // Non-contiguous TKEEP on the last beat: error, beat taken as full
    do_reset();
    chk("err_cleared", ERR, 0);
    set_abc();
    make_beats(3'd0, 1'b0);
    bq_keep[1] = 2'b01;
    g_msg.push_back(bq_dat[1][7:0]);
    model(3'd0);
    xfer();
    chk("gap_err", ERR, 1);

    do_reset();
    set_abc();
`ifdef SHA3_ABSORB_SHAKE_EN
    run_msg(3'b100, 1'b0);
    chk("shake128_b3",   last_blk[31:24], 8'h1F);
    chk("shake128_b167", last_blk[167*8 +: 8], 8'h80);
    chk("shake_no_err",  ERR, 0);
`else
    run_msg(3'b101, 1'b0);
    chk("tuser2_err", ERR, 1);
    chk("tuser2_b135", last_blk[135*8 +: 8], 8'h80);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
